// File: rtl/stove_cook_station.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : stove_cook_station
//  Description : One stove slot. Holds a 12-bit item (four 3-bit ingredient
//                fields) and advances it raw -> cooked -> burnt over time.
//                The player takes the item back with take_req.
//  Revision    : 1.0  initial release
// ============================================================================
module stove_cook_station #(
    parameter int TICK_DIV   = 100_000,
    parameter int COOK_TICKS = 3000,
    parameter int BURN_TICKS = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        place_valid,
    input  logic [11:0] place_data,
    output logic        place_ready,
    input  logic        take_req,
    output logic [11:0] take_data,
    output logic [1:0]  state,
    output logic [7:0]  progress,
    output logic        done_pulse,
    output logic        burnt_pulse
);

    localparam int                   c_presc_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);
    localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);
    localparam logic [15:0]          c_cook_last = 16'(COOK_TICKS - 1);
    localparam logic [15:0]          c_burn_last = 16'(BURN_TICKS - 1);
    localparam logic [23:0]          c_cook_div  = 24'(COOK_TICKS);
    localparam logic [23:0]          c_burn_div  = 24'(BURN_TICKS);
    localparam logic [2:0]           c_raw       = 3'b100;
    localparam logic [2:0]           c_cooked    = 3'b101;
    localparam logic [2:0]           c_burnt     = 3'b110;

    // Code 11 covers both "burnt" and "hold" (item with nothing to cook).
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COOKING = 2'b01,
        ST_DONE    = 2'b10,
        ST_BURNT   = 2'b11
    } state_t;

    state_t                 state_q,       state_d;
    logic [11:0]            contents_q,    contents_d;
    logic [c_presc_w-1:0]   presc_q,       presc_d;
    logic [15:0]            ticks_q,       ticks_d;
    logic                   done_pulse_q,  done_pulse_d;
    logic                   burnt_pulse_q, burnt_pulse_d;

    logic                   w_timed;
    logic                   w_tick;
    logic [23:0]            w_scaled;
    logic [23:0]            w_cook_quot;
    logic [23:0]            w_burn_quot;

    // True when any of the four ingredient fields carries the given code.
    function automatic logic has_code(input logic [11:0] item, input logic [2:0] code);
        logic hit;
        hit = 1'b0;
        for (int f = 0; f < 4; f++) begin
            if (item[f*3 +: 3] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    // Rewrites every field holding from_code to to_code; other fields untouched.
    function automatic logic [11:0] swap_code(input logic [11:0] item,
                                              input logic [2:0]  from_code,
                                              input logic [2:0]  to_code);
        logic [11:0] res;
        res = item;
        for (int f = 0; f < 4; f++) begin
            if (item[f*3 +: 3] == from_code) res[f*3 +: 3] = to_code;
        end
        return res;
    endfunction

    assign w_timed = (state_q == ST_COOKING) || (state_q == ST_DONE);
    assign w_tick  = w_timed && (presc_q == c_presc_max);

    // Next-state, contents transform and timer bookkeeping.
    always_comb begin
        state_d       = state_q;
        contents_d    = contents_q;
        presc_d       = presc_q;
        ticks_d       = ticks_q;
        done_pulse_d  = 1'b0;
        burnt_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (place_valid && (place_data != 12'h000)) begin
                    contents_d = place_data;
                    if (has_code(place_data, c_raw))
                        state_d = ST_COOKING;
                    else if (has_code(place_data, c_cooked))
                        state_d = ST_DONE;
                    else
                        state_d = ST_BURNT;
                end
            end
            ST_COOKING: begin
                // Taking the item beats a simultaneous expiry.
                if (take_req) begin
                    state_d    = ST_IDLE;
                    contents_d = 12'h000;
                end else if (w_tick && (ticks_q == c_cook_last)) begin
                    contents_d   = swap_code(contents_q, c_raw, c_cooked);
                    state_d      = ST_DONE;
                    done_pulse_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (take_req) begin
                    state_d    = ST_IDLE;
                    contents_d = 12'h000;
                end else if (w_tick && (ticks_q == c_burn_last)) begin
                    contents_d    = swap_code(contents_q, c_cooked, c_burnt);
                    state_d       = ST_BURNT;
                    burnt_pulse_d = 1'b1;
                end
            end
            default: begin
                if (take_req) begin
                    state_d    = ST_IDLE;
                    contents_d = 12'h000;
                end
            end
        endcase

        // Timers restart on every state change; they only run in timed states.
        if (state_d != state_q) begin
            presc_d = '0;
            ticks_d = 16'h0000;
        end else if (w_tick) begin
            presc_d = '0;
            ticks_d = ticks_q + 16'h0001;
        end else if (w_timed) begin
            presc_d = presc_q + c_presc_one;
        end
    end

    // State and timer registers; reset discards the item at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            contents_q    <= 12'h000;
            presc_q       <= '0;
            ticks_q       <= 16'h0000;
            done_pulse_q  <= 1'b0;
            burnt_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            contents_q    <= contents_d;
            presc_q       <= presc_d;
            ticks_q       <= ticks_d;
            done_pulse_q  <= done_pulse_d;
            burnt_pulse_q <= burnt_pulse_d;
        end
    end

    // Each limit is a constant, so each quotient is a divide by a constant.
    assign w_scaled    = {ticks_q, 8'h00};
    assign w_cook_quot = w_scaled / c_cook_div;
    assign w_burn_quot = w_scaled / c_burn_div;

    // Progress bar: scaled elapsed ticks, saturated; full once static.
    always_comb begin
        progress = 8'h00;
        case (state_q)
            ST_IDLE:    progress = 8'h00;
            ST_COOKING: progress = (w_cook_quot > 24'd255) ? 8'hFF : w_cook_quot[7:0];
            ST_DONE:    progress = (w_burn_quot > 24'd255) ? 8'hFF : w_burn_quot[7:0];
            default:    progress = 8'hFF;
        endcase
    end

    assign place_ready = (state_q == ST_IDLE);
    assign take_data   = contents_q;
    assign state       = state_q;
    assign done_pulse  = done_pulse_q;
    assign burnt_pulse = burnt_pulse_q;

endmodule
`default_nettype wire
